vga_timing: RTL and testbench

Free-running VGA raster timing generator for the 1024×768 @ 60 Hz mode at a 65 MHz pixel clock. It is the first stage of the video pipeline, and its defaults are taken from the vga_pkg constants. It produces the horizontal and vertical pixel counters, sync and blanking strobes, a start-of-frame pulse and a frame counter. Downstream draw stages (background, rectangle, character, mouse) consume these signals and add their own pipeline delays.

---
 rtl/vga_timing.sv | 95 +++++++++
 tb/tb_vga_timing.sv | 127 ++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// Free-running VGA raster timing generator (1024x768 @ 60 Hz defaults, 65 MHz pixel clock).
// Counters and flags are registered together from the next-state values, so all outputs are flops.
module vga_timing #(
  parameter int HOR_TOTAL       = 1344,
  parameter int HOR_BLANK_START = 1024,
  parameter int HOR_SYNC_START  = 1048,
  parameter int HOR_SYNC_END    = 1184,
  parameter int VER_TOTAL       = 806,
  parameter int VER_BLANK_START = 768,
  parameter int VER_SYNC_START  = 771,
  parameter int VER_SYNC_END    = 777
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblnk,
  output logic        vblnk,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam logic [10:0] H_LAST = 11'(HOR_TOTAL - 1);
  localparam logic [10:0] H_TOT  = 11'(HOR_TOTAL);
  localparam logic [10:0] H_BLK  = 11'(HOR_BLANK_START);
  localparam logic [10:0] H_SS   = 11'(HOR_SYNC_START);
  localparam logic [10:0] H_SE   = 11'(HOR_SYNC_END);
  localparam logic [10:0] V_LAST = 11'(VER_TOTAL - 1);
  localparam logic [10:0] V_TOT  = 11'(VER_TOTAL);
  localparam logic [10:0] V_BLK  = 11'(VER_BLANK_START);
  localparam logic [10:0] V_SS   = 11'(VER_SYNC_START);
  localparam logic [10:0] V_SE   = 11'(VER_SYNC_END);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        frame_start_q, frame_start_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        h_wrap;
  logic        f_wrap;

  // Flags are decoded from the next counter values so they land in the same cycle as the counters.
  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    f_wrap   = h_wrap && (vcount_q == V_LAST);
    hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = (vcount_q == V_LAST) ? 11'd0 : vcount_q + 11'd1;
    end
    hblnk_d       = (hcount_d >= H_BLK) && (hcount_d < H_TOT);
    hsync_d       = (hcount_d >= H_SS)  && (hcount_d < H_SE);
    vblnk_d       = (vcount_d >= V_BLK) && (vcount_d < V_TOT);
    vsync_d       = (vcount_d >= V_SS)  && (vcount_d < V_SE);
    frame_start_d = f_wrap;
    frame_cnt_d   = f_wrap ? frame_cnt_q + 8'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 11'd0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default 1024x768 mode and a tiny 10x5 mode, both compared every cycle
// against an arithmetic raster model driven by the number of unreset edges since reset.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_b, rst_n_s;
  logic [10:0] hcount_b, vcount_b, hcount_s, vcount_s;
  logic        hsync_b, vsync_b, hblnk_b, vblnk_b, fs_b;
  logic        hsync_s, vsync_s, hblnk_s, vblnk_s, fs_s;
  logic [7:0]  fc_b, fc_s;

  vga_timing u_big (
    .clk(clk), .rst_n(rst_n_b), .hcount(hcount_b), .vcount(vcount_b),
    .hsync(hsync_b), .vsync(vsync_b), .hblnk(hblnk_b), .vblnk(vblnk_b),
    .frame_start(fs_b), .frame_cnt(fc_b)
  );

  vga_timing #(
    .HOR_TOTAL(10), .HOR_BLANK_START(6), .HOR_SYNC_START(7), .HOR_SYNC_END(9),
    .VER_TOTAL(5),  .VER_BLANK_START(3), .VER_SYNC_START(4), .VER_SYNC_END(5)
  ) u_small (
    .clk(clk), .rst_n(rst_n_s), .hcount(hcount_s), .vcount(vcount_s),
    .hsync(hsync_s), .vsync(vsync_s), .hblnk(hblnk_s), .vblnk(vblnk_s),
    .frame_start(fs_s), .frame_cnt(fc_s)
  );

  int     checks = 0;
  int     failures = 0;
  longint t_b, t_s;
  bit     measure;
  int     hs_b_cnt, hb_b_cnt, hs_s_cnt, vs_s_cnt, vb_s_cnt, fs_s_cnt;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Raster position follows from elapsed pixels alone: t mod line, line mod frame, frame mod 256.
  task automatic check_mode(input string p, input longint t,
                            input int ht, input int hb, input int hss, input int hse,
                            input int vt, input int vb, input int vss, input int vse,
                            input logic [10:0] h_o, input logic [10:0] v_o,
                            input logic hs_o, input logic vs_o, input logic hb_o, input logic vb_o,
                            input logic fs_o, input logic [7:0] fc_o);
    longint fr, h, v;
    fr = longint'(ht) * longint'(vt);
    h  = t % ht;
    v  = (t / ht) % vt;
    check_eq({p, "_hcount"}, h_o, h);
    check_eq({p, "_vcount"}, v_o, v);
    check_eq({p, "_hsync"},  hs_o, (h >= hss && h < hse) ? 1 : 0);
    check_eq({p, "_hblnk"},  hb_o, (h >= hb && h < ht) ? 1 : 0);
    check_eq({p, "_vsync"},  vs_o, (v >= vss && v < vse) ? 1 : 0);
    check_eq({p, "_vblnk"},  vb_o, (v >= vb && v < vt) ? 1 : 0);
    check_eq({p, "_frame_start"}, fs_o, (t > 0 && t % fr == 0) ? 1 : 0);
    check_eq({p, "_frame_cnt"}, fc_o, (t / fr) % 256);
  endtask

  task automatic step();
    @(posedge clk);
    t_b = rst_n_b ? t_b + 1 : 0;
    t_s = rst_n_s ? t_s + 1 : 0;
    #1;
    check_mode("big", t_b, 1344, 1024, 1048, 1184, 806, 768, 771, 777,
               hcount_b, vcount_b, hsync_b, vsync_b, hblnk_b, vblnk_b, fs_b, fc_b);
    check_mode("small", t_s, 10, 6, 7, 9, 5, 3, 4, 5,
               hcount_s, vcount_s, hsync_s, vsync_s, hblnk_s, vblnk_s, fs_s, fc_s);
    if (measure) begin
      if (vcount_b == 11'd1) begin
        hs_b_cnt += int'(hsync_b);
        hb_b_cnt += int'(hblnk_b);
      end
      if (fc_s == 8'd3) begin
        hs_s_cnt += int'(hsync_s);
        vs_s_cnt += int'(vsync_s);
        vb_s_cnt += int'(vblnk_s);
      end
      fs_s_cnt += int'(fs_s);
    end
  endtask

  initial begin
    t_b = 0; t_s = 0; measure = 1'b0;
    hs_b_cnt = 0; hb_b_cnt = 0; hs_s_cnt = 0; vs_s_cnt = 0; vb_s_cnt = 0; fs_s_cnt = 0;
    rst_n_b = 1'b0; rst_n_s = 1'b0;
    repeat (3) step();
    rst_n_b = 1'b1; rst_n_s = 1'b1;
    repeat (500) step();

    // Mid-count resets of random length at random points, independently per instance.
    for (int k = 0; k < 5; k++) begin
      int n;
      n = $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 0) rst_n_b = 1'b0;
      else rst_n_s = 1'b0;
      if (k == 0) rst_n_b = 1'b0;
      repeat (n) step();
      rst_n_b = 1'b1; rst_n_s = 1'b1;
      repeat ($urandom_range(50, 1500)) step();
    end

    // Clean run: 256 small frames plus margin, covering several full default lines.
    rst_n_b = 1'b0; rst_n_s = 1'b0;
    step();
    rst_n_b = 1'b1; rst_n_s = 1'b1;
    measure = 1'b1;
    repeat (256 * 50 + 10) step();
    measure = 1'b0;

    check_eq("big_hsync_width", hs_b_cnt, 136);
    check_eq("big_hblnk_width", hb_b_cnt, 320);
    check_eq("small_hsync_per_frame", hs_s_cnt, 5 * 2);
    check_eq("small_vsync_cycles", vs_s_cnt, 1 * 10);
    check_eq("small_vblnk_cycles", vb_s_cnt, 2 * 10);
    check_eq("small_frame_pulses", fs_s_cnt, 256);
    check_eq("small_frame_cnt_wrapped", fc_s, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
